// File: rtl/tuple_classifier.sv
// Inline AXI-Stream 5-tuple parser and single-rule dropper; data passes through combinationally.
// Verdict is registered one cycle after tlast acceptance; valid/ready are gated by result_nearly_full.
module tuple_classifier #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              rule_en,
  input  logic [31:0]                       rule_src_addr,
  input  logic [31:0]                       rule_src_mask,
  input  logic [7:0]                        rule_proto,
  input  logic [15:0]                       rule_dst_port,
  output logic                              result_wr_en,
  output logic [104:0]                      result_din,
  input  logic                              result_nearly_full,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       drop_count
);

  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, EMIT} state_t;

  state_t        r_state;
  logic [15:0]   r_etype;
  logic [7:0]    r_verihl;
  logic [7:0]    r_proto;
  logic [31:0]   r_src;
  logic [15:0]   r_dst_hi;
  logic [15:0]   r_dst_lo;
  logic [15:0]   r_sport;
  logic [15:0]   r_dport;
  logic          r_wr_en;
  logic [104:0]  r_din;
  logic [31:0]   r_pkt;
  logic [31:0]   r_drop;

  logic          w_accept;
  logic          w_first;
  logic          w_in_hdr1;
  logic          w_ihl5;
  logic          w_l4;
  logic          w_ipv4;
  logic          w_drop;
  logic [31:0]   w_dst;
  logic [15:0]   w_sport;
  logic [15:0]   w_dport;
  logic [104:0]  w_verdict;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & ~result_nearly_full;
  assign s_axis_tready = m_axis_tready & ~result_nearly_full;

  assign w_accept     = s_axis_tvalid & s_axis_tready;
  assign result_wr_en = r_wr_en;
  assign result_din   = r_din;
  assign pkt_count    = r_pkt;
  assign drop_count   = r_drop;

  // In HDR1 the tlast beat itself carries dst-low and ports, so bypass the latches.
  always_comb begin
    w_first   = (r_state == HDR0) || (r_state == EMIT);
    w_in_hdr1 = (r_state == HDR1);
    w_ihl5    = (r_verihl[3:0] == 4'd5);
    w_l4      = w_ihl5 && ((r_proto == 8'd6) || (r_proto == 8'd17));
    w_ipv4    = (r_etype == 16'h0800) && (r_verihl[7:4] == 4'd4);
    w_dst     = {r_dst_hi, w_in_hdr1 ? s_axis_tdata[255:240] : r_dst_lo};
    w_sport   = 16'd0;
    w_dport   = 16'd0;
    if (w_l4) begin
      w_sport = w_in_hdr1 ? s_axis_tdata[239:224] : r_sport;
      w_dport = w_in_hdr1 ? s_axis_tdata[223:208] : r_dport;
    end
    w_drop = rule_en
           && (((r_src ^ rule_src_addr) & rule_src_mask) == 32'd0)
           && ((rule_proto == 8'd0) || (r_proto == rule_proto))
           && ((rule_dst_port == 16'd0) || (w_dport == rule_dst_port));
    w_verdict = {1'b1, 104'd0};
    if (!w_first && w_ipv4)
      w_verdict = {~w_drop, r_src, w_dst, w_sport, w_dport, r_proto};
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state  <= HDR0;
      r_etype  <= '0;
      r_verihl <= '0;
      r_proto  <= '0;
      r_src    <= '0;
      r_dst_hi <= '0;
      r_dst_lo <= '0;
      r_sport  <= '0;
      r_dport  <= '0;
      r_wr_en  <= 1'b0;
      r_din    <= '0;
      r_pkt    <= '0;
      r_drop   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en) begin
        r_pkt <= r_pkt + 32'd1;
        if (!r_din[104]) r_drop <= r_drop + 32'd1;
      end
      if (w_accept) begin
        unique case (r_state)
          HDR0, EMIT: begin
            r_etype  <= s_axis_tdata[159:144];
            r_verihl <= s_axis_tdata[143:136];
            r_proto  <= s_axis_tdata[71:64];
            r_src    <= s_axis_tdata[47:16];
            r_dst_hi <= s_axis_tdata[15:0];
            r_sport  <= '0;
            r_dport  <= '0;
            r_state  <= s_axis_tlast ? EMIT : HDR1;
          end
          HDR1: begin
            r_dst_lo <= s_axis_tdata[255:240];
            if (w_ihl5) begin
              r_sport <= s_axis_tdata[239:224];
              r_dport <= s_axis_tdata[223:208];
            end
            r_state <= s_axis_tlast ? EMIT : PAYLOAD;
          end
          PAYLOAD: if (s_axis_tlast) r_state <= EMIT;
        endcase
        if (s_axis_tlast) begin
          r_wr_en <= 1'b1;
          r_din   <= w_verdict;
        end
      end else if (r_state == EMIT) begin
        r_state <= HDR0;
      end
    end
  end

endmodule

// File: tb/tb_tuple_classifier.sv
// Bench for tuple_classifier: directed scenarios plus randomized packets against a byte-level model.
module tb_tuple_classifier;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tstrb;
  logic [127:0]  s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tstrb;
  logic [127:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          rule_en;
  logic [31:0]   rule_src_addr;
  logic [31:0]   rule_src_mask;
  logic [7:0]    rule_proto;
  logic [15:0]   rule_dst_port;
  logic          result_wr_en;
  logic [104:0]  result_din;
  logic          result_nearly_full;
  logic [31:0]   pkt_count;
  logic [31:0]   drop_count;

  tuple_classifier dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .rule_en(rule_en), .rule_src_addr(rule_src_addr), .rule_src_mask(rule_src_mask),
    .rule_proto(rule_proto), .rule_dst_port(rule_dst_port),
    .result_wr_en(result_wr_en), .result_din(result_din), .result_nearly_full(result_nearly_full),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  int passed = 0, total = 0;
  int cyc = 0, acc_beats = 0, pt_bad = 0, last_acc = 0;
  int exp_pkt = 0, exp_drop = 0;
  bit rand_bp = 0;
  logic [7:0]   pkt [0:95];
  logic [104:0] wr_q [$];
  int           wr_cyc_q [$];

  // Observer: write capture with cycle stamps, accepted-beat count, passthrough integrity.
  always @(negedge axi_aclk) begin
    cyc = cyc + 1;
    if (result_wr_en) begin
      wr_q.push_back(result_din);
      wr_cyc_q.push_back(cyc);
    end
    if (s_axis_tvalid && s_axis_tready) acc_beats = acc_beats + 1;
    if (m_axis_tdata !== s_axis_tdata || m_axis_tstrb !== s_axis_tstrb ||
        m_axis_tuser !== s_axis_tuser || m_axis_tlast !== s_axis_tlast ||
        m_axis_tvalid !== (s_axis_tvalid & ~result_nearly_full) ||
        s_axis_tready !== (m_axis_tready & ~result_nearly_full))
      pt_bad = pt_bad + 1;
  end

  task automatic build_pkt(input logic [15:0] etype, input logic [7:0] verihl, input logic [7:0] proto,
                           input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] sp, input logic [15:0] dp);
    for (int i = 0; i < 96; i++) pkt[i] = 8'($urandom);
    {pkt[12], pkt[13]} = etype;
    pkt[14] = verihl;
    pkt[23] = proto;
    {pkt[26], pkt[27], pkt[28], pkt[29]} = src;
    {pkt[30], pkt[31], pkt[32], pkt[33]} = dst;
    {pkt[34], pkt[35]} = sp;
    {pkt[36], pkt[37]} = dp;
  endtask

  // Reference: expected verdict computed straight from the packet bytes and the rule inputs.
  function automatic logic [104:0] ref_verdict(input int nbeats);
    logic [15:0] etype, sp, dp;
    logic [31:0] src, dst;
    logic [7:0]  proto;
    int          ihl, ver;
    bit          drop;
    etype = {pkt[12], pkt[13]};
    ver   = int'(pkt[14] >> 4);
    ihl   = int'(pkt[14] & 8'h0F);
    if (nbeats == 1 || etype != 16'h0800 || ver != 4) return {1'b1, 104'd0};
    proto = pkt[23];
    src   = {pkt[26], pkt[27], pkt[28], pkt[29]};
    dst   = {pkt[30], pkt[31], pkt[32], pkt[33]};
    sp = 0;
    dp = 0;
    if (ihl == 5 && (proto == 6 || proto == 17)) begin
      sp = {pkt[34], pkt[35]};
      dp = {pkt[36], pkt[37]};
    end
    drop = rule_en && ((src & rule_src_mask) == (rule_src_addr & rule_src_mask)) &&
           (rule_proto == 0 || rule_proto == proto) && (rule_dst_port == 0 || rule_dst_port == dp);
    return {!drop, src, dst, sp, dp, proto};
  endfunction

  task automatic set_beat(input int b, input bit last);
    for (int i = 0; i < 32; i++) s_axis_tdata[255-8*i -: 8] = pkt[b*32+i];
    s_axis_tstrb  = $urandom;
    s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
  endtask

  task automatic drive_beat(input int b, input bit last);
    int tries = 0;
    set_beat(b, last);
    forever begin
      if (rand_bp) m_axis_tready = ($urandom_range(0, 3) != 0);
      @(negedge axi_aclk);
      if (s_axis_tready) break;
      @(posedge axi_aclk); #1;
      tries++;
      if (tries > 200) begin
        total++;
        $display("FAIL beat_accept_timeout beat=%0d ready=%b required=1", b, s_axis_tready);
        break;
      end
    end
    @(posedge axi_aclk); #1;
    last_acc = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic send_pkt(input int nbeats);
    for (int b = 0; b < nbeats; b++) drive_beat(b, b == nbeats - 1);
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_q.size() < n && t < 20) begin
      @(posedge axi_aclk); #1;
      t++;
    end
  endtask

  task automatic test_reset;
    total++; if (result_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", result_wr_en); else passed++;
    total++; if (result_din !== 105'd0) $display("FAIL reset_din got=%h exp=0", result_din); else passed++;
    total++; if (pkt_count !== 32'd0 || drop_count !== 32'd0)
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", pkt_count, drop_count); else passed++;
  endtask

  task automatic test_tcp_drop;
    logic [104:0] got; int gc;
    build_pkt(16'h0800, 8'h45, 8'd6, 32'h0A000005, 32'hC0A80001, 16'h1234, 16'd80);
    rule_en = 1; rule_src_addr = 32'h0A000005; rule_src_mask = 32'hFFFFFFFF; rule_proto = 6; rule_dst_port = 80;
    send_pkt(3);
    wait_wr(1);
    gc  = (wr_cyc_q.size() > 0) ? wr_cyc_q.pop_front() : -1;
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    total++; if (got !== {1'b0, 32'h0A000005, 32'hC0A80001, 16'h1234, 16'h0050, 8'h06})
      $display("FAIL tcp_drop_din got=%h exp=%h", got, {1'b0, 32'h0A000005, 32'hC0A80001, 16'h1234, 16'h0050, 8'h06}); else passed++;
    total++; if (gc != last_acc + 1) $display("FAIL tcp_latency got=%0d exp=%0d", gc, last_acc + 1); else passed++;
    repeat (2) @(posedge axi_aclk); #1;
    exp_pkt++; exp_drop++;
    total++; if (drop_count !== 32'd1 || pkt_count !== 32'd1)
      $display("FAIL tcp_counters got=%0d/%0d exp=1/1", pkt_count, drop_count); else passed++;
  endtask

  task automatic test_tcp_pass;
    logic [104:0] got;
    rule_dst_port = 443;
    send_pkt(3);
    wait_wr(1);
    void'(wr_cyc_q.pop_front());
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    total++; if (got !== {1'b1, 32'h0A000005, 32'hC0A80001, 16'h1234, 16'h0050, 8'h06})
      $display("FAIL tcp_pass_din got=%h", got); else passed++;
    repeat (2) @(posedge axi_aclk); #1;
    exp_pkt++;
    total++; if (pkt_count !== exp_pkt || drop_count !== exp_drop)
      $display("FAIL tcp_pass_counters got=%0d/%0d exp=%0d/%0d", pkt_count, drop_count, exp_pkt, exp_drop); else passed++;
  endtask

  task automatic test_arp;
    logic [104:0] got;
    build_pkt(16'h0806, 8'h45, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2);
    rule_en = 1; rule_src_mask = 0; rule_proto = 0; rule_dst_port = 0;
    send_pkt(2);
    wait_wr(1);
    void'(wr_cyc_q.pop_front());
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    exp_pkt++;
    total++; if (got !== {1'b1, 104'd0}) $display("FAIL arp_din got=%h exp=%h", got, {1'b1, 104'd0}); else passed++;
  endtask

  task automatic test_nearly_full;
    logic [104:0] got, exp; int b0, stall_bad;
    build_pkt(16'h0800, 8'h45, 8'd17, 32'hAC100001, 32'hAC100002, 16'd5353, 16'd53);
    rule_en = 1; rule_src_addr = 32'hAC100000; rule_src_mask = 32'hFFFF0000; rule_proto = 17; rule_dst_port = 53;
    exp = ref_verdict(3);
    b0 = acc_beats;
    drive_beat(0, 0);
    set_beat(1, 0);
    result_nearly_full = 1;
    stall_bad = 0;
    repeat (5) begin
      @(negedge axi_aclk);
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) stall_bad++;
    end
    @(posedge axi_aclk); #1;
    result_nearly_full = 0;
    drive_beat(1, 0);
    drive_beat(2, 1);
    wait_wr(1);
    void'(wr_cyc_q.pop_front());
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    exp_pkt++; if (!exp[104]) exp_drop++;
    total++; if (stall_bad != 0) $display("FAIL nf_gating got=%0d bad cycles exp=0", stall_bad); else passed++;
    total++; if (acc_beats - b0 != 3) $display("FAIL nf_beats got=%0d exp=3", acc_beats - b0); else passed++;
    total++; if (got !== exp) $display("FAIL nf_din got=%h exp=%h", got, exp); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [104:0] g1, g2, e2; int c1, c2, a1, a2;
    rule_en = 1; rule_src_mask = 0; rule_proto = 0; rule_dst_port = 0;
    build_pkt(16'h0800, 8'h45, 8'd6, 32'h11111111, 32'h22222222, 16'd7, 16'd8);
    drive_beat(0, 1);
    a1 = last_acc;
    build_pkt(16'h0800, 8'h45, 8'd17, 32'h33333333, 32'h44444444, 16'd9, 16'd10);
    e2 = ref_verdict(2);
    send_pkt(2);
    a2 = last_acc;
    wait_wr(2);
    c1 = (wr_cyc_q.size() > 0) ? wr_cyc_q.pop_front() : -1;
    c2 = (wr_cyc_q.size() > 0) ? wr_cyc_q.pop_front() : -1;
    g1 = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    g2 = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    exp_pkt += 2; if (!e2[104]) exp_drop++;
    total++; if (g1 !== {1'b1, 104'd0}) $display("FAIL b2b_single_din got=%h", g1); else passed++;
    total++; if (g2 !== e2) $display("FAIL b2b_udp_din got=%h exp=%h", g2, e2); else passed++;
    total++; if (c1 != a1 + 1 || c2 != a2 + 1)
      $display("FAIL b2b_latency got=%0d,%0d exp=%0d,%0d", c1, c2, a1 + 1, a2 + 1); else passed++;
  endtask

  task automatic test_abort_reset;
    logic [104:0] got, exp;
    build_pkt(16'h0800, 8'h45, 8'd6, 32'h55555555, 32'h66666666, 16'd11, 16'd12);
    drive_beat(0, 0);
    axi_aresetn = 0;
    repeat (2) @(posedge axi_aclk); #1;
    total++; if (pkt_count !== 0 || drop_count !== 0 || result_wr_en !== 0)
      $display("FAIL abort_reset_state got=%0d/%0d/%b exp=0/0/0", pkt_count, drop_count, result_wr_en); else passed++;
    axi_aresetn = 1;
    wr_q.delete(); wr_cyc_q.delete();
    exp_pkt = 0; exp_drop = 0;
    rule_en = 1; rule_src_addr = 32'h77777777; rule_src_mask = 32'hFFFFFFFF; rule_proto = 0; rule_dst_port = 0;
    build_pkt(16'h0800, 8'h45, 8'd6, 32'h77777777, 32'h88888888, 16'd13, 16'd14);
    exp = ref_verdict(2);
    send_pkt(2);
    wait_wr(1);
    repeat (3) @(posedge axi_aclk); #1;
    total++; if (wr_q.size() != 1) $display("FAIL abort_writes got=%0d exp=1", wr_q.size()); else passed++;
    void'(wr_cyc_q.pop_front());
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
    total++; if (got !== exp) $display("FAIL abort_new_din got=%h exp=%h", got, exp); else passed++;
    total++; if (pkt_count !== 1) $display("FAIL abort_pkt_count got=%0d exp=1", pkt_count); else passed++;
    exp_pkt = 1; if (!exp[104]) exp_drop = 1;
  endtask

  task automatic test_random;
    logic [104:0] got, exp; logic [31:0] src; logic [15:0] dp; logic [7:0] proto, vi; logic [15:0] et;
    int nb, kind, errs, lat_errs;
    errs = 0; lat_errs = 0;
    rand_bp = 1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      nb = $urandom_range(1, 3);
      src = $urandom; dp = 16'($urandom_range(0, 3) == 0 ? 80 : $urandom);
      et = (kind == 3) ? 16'h0806 : 16'h0800;
      vi = (kind == 4) ? 8'h46 : (kind == 5) ? 8'h65 : 8'h45;
      proto = (kind == 1) ? 8'd17 : (kind == 2) ? 8'd1 : 8'd6;
      build_pkt(et, vi, proto, src, $urandom, 16'($urandom), dp);
      rule_en = ($urandom_range(0, 3) != 0);
      rule_src_addr = $urandom_range(0, 1) ? src : $urandom;
      case ($urandom_range(0, 3))
        0: rule_src_mask = 32'hFFFFFFFF;
        1: rule_src_mask = 32'hFFFFFF00;
        2: rule_src_mask = 32'h0;
        default: rule_src_mask = $urandom;
      endcase
      rule_proto = $urandom_range(0, 1) ? 8'd0 : ($urandom_range(0, 1) ? proto : 8'($urandom));
      rule_dst_port = $urandom_range(0, 1) ? 16'd0 : ($urandom_range(0, 1) ? dp : 16'($urandom));
      exp = ref_verdict(nb);
      send_pkt(nb);
      wait_wr(1);
      if ((wr_cyc_q.size() > 0 ? wr_cyc_q.pop_front() : -1) != last_acc + 1) lat_errs++;
      got = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
      exp_pkt++; if (!exp[104]) exp_drop++;
      if (got !== exp) begin
        errs++;
        $display("FAIL random_din pkt=%0d got=%h exp=%h", n, got, exp);
      end
    end
    rand_bp = 0;
    repeat (2) @(posedge axi_aclk); #1;
    total++; if (errs != 0) $display("FAIL random_verdicts got=%0d wrong exp=0", errs); else passed++;
    total++; if (lat_errs != 0) $display("FAIL random_latency got=%0d wrong exp=0", lat_errs); else passed++;
    total++; if (pkt_count !== exp_pkt || drop_count !== exp_drop)
      $display("FAIL random_counters got=%0d/%0d exp=%0d/%0d", pkt_count, drop_count, exp_pkt, exp_drop); else passed++;
    total++; if (pt_bad != 0) $display("FAIL passthrough got=%0d bad cycles exp=0", pt_bad); else passed++;
  endtask

  initial begin
    axi_aresetn = 0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
    m_axis_tready = 1; result_nearly_full = 0;
    rule_en = 0; rule_src_addr = 0; rule_src_mask = 0; rule_proto = 0; rule_dst_port = 0;
    repeat (3) @(posedge axi_aclk); #1;
    test_reset();
    axi_aresetn = 1;
    @(posedge axi_aclk); #1;
    test_tcp_drop();
    test_tcp_pass();
    test_arp();
    test_nearly_full();
    test_back_to_back();
    test_abort_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tuple_classifier.md
Name: tuple_classifier

Overview:
- Inline AXI-Stream stage placed directly upstream of the packet store/forward FIFO stage.
- Parses Ethernet/IPv4/TCP/UDP headers from 256-bit beats and extracts the 5-tuple.
- Evaluates one programmable drop rule and writes one 105-bit verdict per packet into the result FIFO. The store stage pops that verdict to forward or discard the packet.
- Data passes through unmodified. Back-pressure comes only from the downstream stage and from result FIFO fullness.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, stream data width; only 256 is supported.
- C_M_AXIS_DATA_WIDTH, 256, must equal C_S_AXIS_DATA_WIDTH.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width, passed through.
- C_M_AXIS_TUSER_WIDTH, 128, must equal C_S_AXIS_TUSER_WIDTH.

Ports:
- axi_aclk  in  1  single clock.
- axi_aresetn  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  256  packet data; byte 0 of each beat is at [255:248].
- s_axis_tstrb  in  32  byte strobes, passed through.
- s_axis_tuser  in  128  metadata, passed through.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  equals m_axis_tready & ~result_nearly_full.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata / m_axis_tstrb / m_axis_tuser / m_axis_tlast  out  256/32/128/1  combinational copies of the s_axis fields.
- m_axis_tvalid  out  1  equals s_axis_tvalid & ~result_nearly_full.
- m_axis_tready  in  1  downstream ready.
- rule_en  in  1  enables the drop rule.
- rule_src_addr  in  32  IPv4 source address to match.
- rule_src_mask  in  32  source match mask.
- rule_proto  in  8  protocol to match; 0 is a wildcard.
- rule_dst_port  in  16  destination port to match; 0 is a wildcard.
- result_wr_en  out  1  one-cycle write strobe to the result FIFO.
- result_din  out  105  verdict word: [104] pass (1 = forward), [103:72] src IP, [71:40] dst IP, [39:24] src port, [23:8] dst port, [7:0] protocol.
- result_nearly_full  in  1  result FIFO almost full.
- pkt_count  out  32  number of verdicts written.
- drop_count  out  32  number of verdicts written with pass=0.

Behaviour:
- A beat counts as accepted when s_axis_tvalid & s_axis_tready.
- The block gates both the input and output valid/ready with ~result_nearly_full. Nearly_full guarantees at least one free FIFO slot, which covers the single verdict that can be in flight.
- State machine (reset state HDR0):
  - HDR0, on an accepted beat:
    - Latch ethertype (bytes 12-13), version/IHL (byte 14), proto (byte 23), src IP (bytes 26-29), dst IP high half (bytes 30-31).
    - If tlast is set, go to EMIT; otherwise go to HDR1.
  - HDR1, on an accepted beat:
    - Latch dst IP low half (bytes 0-1).
    - If IHL==5, latch src port (bytes 2-3) and dst port (bytes 4-5).
    - If tlast is set, go to EMIT; otherwise go to PAYLOAD.
  - PAYLOAD: on an accepted beat with tlast set, go to EMIT.
  - EMIT: internal one-cycle phase that the registered write happens in (see next item).
- Verdict write:
  - result_wr_en and result_din are registered.
  - Write latency is exactly 1 cycle after acceptance of the tlast beat.
  - EMIT overlaps with HDR0: a new packet's first beat may be accepted in the same cycle as the write.
- Classification rules:
  - Valid IPv4 means ethertype 0x0800 and version 4. Anything else gives pass=1 with all tuple fields zero.
  - A single-beat packet gives pass=1 with all tuple fields zero.
  - Ports are reported as 0 when IHL!=5 or when proto is neither 6 nor 17.
  - drop = rule_en & ((src ^ rule_src_addr) & rule_src_mask)==0 & (rule_proto==0 | proto==rule_proto) & (rule_dst_port==0 | dport==rule_dst_port).
  - pass = ~drop.
- rule_* inputs are sampled in the cycle the verdict is computed (tlast acceptance). Changing them mid-packet affects only the packet whose tlast has not yet been accepted.
- Counters:
  - pkt_count increments on each result_wr_en.
  - drop_count increments when result_wr_en is high and result_din[104]=0.
  - Both wrap modulo 2^32.
- Reset (synchronous, axi_aresetn=0):
  - state goes to HDR0; result_wr_en=0; result_din=0; both counters=0.
  - Any partially parsed packet is abandoned. The next accepted beat is treated as a first beat.
- When result_nearly_full is high, both valid and ready are low. No beat is accepted, and parsing state and latched fields hold.

Test Plan:
1. TCP packet, 3 beats, src 0x0A000005, dst 0xC0A80001, sport 0x1234, dport 80; rule_en=1, src 0x0A000005, mask 0xFFFFFFFF, proto 6, dport 80 -> one result_wr_en 1 cycle after the tlast beat; result_din={0,0x0A000005,0xC0A80001,0x1234,0x0050,0x06}; drop_count=1.
2. Same packet with rule_dst_port=443 -> pass=1, otherwise identical fields; pkt_count increments and drop_count does not.
3. ARP frame (ethertype 0x0806), 2 beats -> result_din={1,0,...,0}.
4. Hold result_nearly_full=1 for 5 cycles mid-packet -> s_axis_tready=0 and m_axis_tvalid=0 throughout; no beat is lost or duplicated; verdict is correct after release.
5. Back-to-back packets: 1-beat packet then 2-beat UDP packet with no idle cycle -> two writes on consecutive tlast acceptances, each correct; the first has tuple zero and pass=1.
6. Assert reset after beat 0 of a packet, then send a full new packet -> no write for the aborted packet; counters read 0, then 1; the new verdict is correct.
